alu_op_sequencer: RTL and testbench

- Controller that sequences the 16-bit ALU datapath.
- Accepts one command at a time over a valid/ready handshake: 4-bit opcode plus two 16-bit operands.
- Decodes the opcode into the ALU's 12-bit one-hot select and holds operands stable for a programmable number of cycles.
- Captures the result, returns it over a second valid/ready handshake, and keeps a result accumulator so commands can chain.

---
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to the 16-bit ALU
// datapath, holds select/operands for ALU_LAT cycles, then returns the
// captured result over a valid/ready handshake and keeps an accumulator.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cmd_valid/ready   command handshake (cmd_op, cmd_a, cmd_b, cmd_use_acc)
//   acc_clr           synchronous accumulator clear
//   alu_sel/a/b       one-hot select and operands to the ALU
//   alu_result/cout   ALU outputs
//   res_valid/ready   result handshake (res_data, res_cout, res_err)
//   acc_q             accumulator
// Optional (ALU_SEQ_STATS_EN): stat_ops, stat_errs saturating counters.
module alu_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             acc_clr,
    output logic [11:0]      alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_err,
    output logic [WIDTH-1:0] acc_q
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_errs
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [11:0] SEL_CLR = 12'h800;
    localparam logic [3:0]  LAT_M1  = 4'(ALU_LAT - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        err_q;
    logic [11:0] dec_sel;
    logic        dec_err;
    logic        cmd_fire;
    logic        res_fire;

    always_comb begin
        dec_sel = SEL_CLR;
        dec_err = 1'b0;
        unique case (cmd_op)
            4'h0: dec_sel = 12'h001;
            4'h1: dec_sel = 12'h002;
            4'h2: dec_sel = 12'h004;
            4'h3: dec_sel = 12'h008;
            4'h4: dec_sel = 12'h010;
            4'h5: dec_sel = 12'h020;
            4'h6: dec_sel = 12'h040;
            4'h8: dec_sel = 12'h080;
            4'h9: dec_sel = 12'h100;
            4'hA: dec_sel = 12'h200;
            4'hB: dec_sel = 12'h400;
            default: begin
                dec_sel = SEL_CLR;
                dec_err = 1'b1;
            end
        endcase
    end

    assign cmd_fire = cmd_valid & cmd_ready;
    assign res_fire = res_valid & res_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cmd_fire)     state_nx = EXEC;
            EXEC:    if (cnt == 4'd0)  state_nx = DONE;
            DONE:    if (res_ready)    state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly
    always_comb begin
        cmd_ready = (state == IDLE);
        res_valid = (state == DONE);
    end

    // Issue/capture datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel  <= SEL_CLR;
            alu_a    <= '0;
            alu_b    <= '0;
            err_q    <= 1'b0;
            cnt      <= 4'd0;
            res_data <= '0;
            res_cout <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        alu_sel <= dec_sel;
                        alu_a   <= cmd_use_acc ? acc_q : cmd_a;
                        alu_b   <= cmd_b;
                        err_q   <= dec_err;
                        cnt     <= LAT_M1;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Illegal commands return zero regardless of ALU
                        res_data <= err_q ? '0 : alu_result;
                        res_cout <= ~err_q & alu_cout;
                        res_err  <= err_q;
                        alu_sel  <= SEL_CLR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator: clear has priority over write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc_q <= '0;
        else if (acc_clr)  acc_q <= '0;
        else if (res_fire) acc_q <= res_data;
    end

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops  <= 16'd0;
            stat_errs <= 16'd0;
        end else if (acc_clr) begin
            stat_ops  <= 16'd0;
            stat_errs <= 16'd0;
        end else if (res_fire) begin
            if (stat_ops != 16'hFFFF)
                stat_ops <= stat_ops + 16'd1;
            if (res_err && stat_errs != 16'hFFFF)
                stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer using one
// instance with ALU_LAT=1 and one with ALU_LAT=3, each with an ALU model.
module tb_alu_op_sequencer;

    logic clk;
    logic rst_n;

    logic        cmd_valid1, cmd_ready1, cmd_use1, acc_clr1;
    logic [3:0]  cmd_op1;
    logic [15:0] cmd_a1, cmd_b1;
    logic [11:0] alu_sel1;
    logic [15:0] alu_a1, alu_b1, alu_result1;
    logic        alu_cout1, res_valid1, res_ready1, res_cout1, res_err1;
    logic [15:0] res_data1, acc_q1;

    logic        cmd_valid3, cmd_ready3, cmd_use3, acc_clr3;
    logic [3:0]  cmd_op3;
    logic [15:0] cmd_a3, cmd_b3;
    logic [11:0] alu_sel3;
    logic [15:0] alu_a3, alu_b3, alu_result3;
    logic        alu_cout3, res_valid3, res_ready3, res_cout3, res_err3;
    logic [15:0] res_data3, acc_q3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_acc1 = 16'h0;
    logic [15:0] exp_acc3 = 16'h0;
    logic [17:0] q1[$];
    logic [17:0] q3[$];

    // ALU datapath model, driven by the one-hot select
    function automatic logic [16:0] alu_f(input logic [11:0] s,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        case (s)
            12'h001: return {1'b0, a & b};
            12'h002: return {1'b0, a | b};
            12'h004: return {1'b0, ~a};
            12'h008: return {1'b0, a ^ b};
            12'h010: return {1'b0, ~(a & b)};
            12'h020: return {1'b0, ~(a | b)};
            12'h040: return {1'b0, ~(a ^ b)};
            12'h080: return {1'b0, a} + {1'b0, b};
            12'h100: return {1'b0, a} - {1'b0, b};
            12'h200: return {a[0], 1'b0, a[15:1]};
            12'h400: return {a[15], a[14:0], 1'b0};
            default: return 17'h1DEAD;
        endcase
    endfunction

    // Expected {err, cout, data} from the opcode
    function automatic logic [17:0] exp_f(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [16:0] s;
        case (op)
            4'h0: return {2'b00, a & b};
            4'h1: return {2'b00, a | b};
            4'h2: return {2'b00, ~a};
            4'h3: return {2'b00, a ^ b};
            4'h4: return {2'b00, ~(a & b)};
            4'h5: return {2'b00, ~(a | b)};
            4'h6: return {2'b00, ~(a ^ b)};
            4'h8: begin s = {1'b0, a} + {1'b0, b}; return {1'b0, s}; end
            4'h9: begin s = {1'b0, a} - {1'b0, b}; return {1'b0, s}; end
            4'hA: return {1'b0, a[0], 1'b0, a[15:1]};
            4'hB: return {1'b0, a[15], a[14:0], 1'b0};
            default: return {2'b10, 16'h0000};
        endcase
    endfunction

    function automatic logic [11:0] exp_sel(input logic [3:0] op);
        logic [11:0] one;
        one = 12'h001;
        if (op <= 4'h6) return one << op;
        if (op >= 4'h8 && op <= 4'hB) return 12'h080 << (op - 4'h8);
        return 12'h800;
    endfunction

    assign {alu_cout1, alu_result1} = alu_f(alu_sel1, alu_a1, alu_b1);
    assign {alu_cout3, alu_result3} = alu_f(alu_sel3, alu_a3, alu_b3);

    alu_op_sequencer #(.WIDTH(16), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op1), .cmd_a(cmd_a1), .cmd_b(cmd_b1),
        .cmd_use_acc(cmd_use1), .acc_clr(acc_clr1),
        .alu_sel(alu_sel1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_result(alu_result1), .alu_cout(alu_cout1),
        .res_valid(res_valid1), .res_ready(res_ready1),
        .res_data(res_data1), .res_cout(res_cout1), .res_err(res_err1),
        .acc_q(acc_q1)
    );

    alu_op_sequencer #(.WIDTH(16), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
        .cmd_use_acc(cmd_use3), .acc_clr(acc_clr3),
        .alu_sel(alu_sel3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_result(alu_result3), .alu_cout(alu_cout3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_data(res_data3), .res_cout(res_cout3), .res_err(res_err3),
        .acc_q(acc_q3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one command into dut1 and check the issued select/operands
    task automatic send1(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic use_acc);
        logic [15:0] ea;
        ea = use_acc ? exp_acc1 : a;
        cmd_op1 = op; cmd_a1 = a; cmd_b1 = b; cmd_use1 = use_acc;
        cmd_valid1 = 1'b1;
        n_tests++;
        if (cmd_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready1 got %b want 1", cmd_ready1);
        end
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        q1.push_back(exp_f(op, ea, b));
        n_tests++;
        if (alu_sel1 !== exp_sel(op) || alu_a1 !== ea || alu_b1 !== b) begin
            n_fail++;
            $display("FAIL issue1 op=%h got sel=%h a=%h b=%h want sel=%h a=%h b=%h",
                     op, alu_sel1, alu_a1, alu_b1, exp_sel(op), ea, b);
        end
    endtask

    // Wait for dut1 result, check it against the scoreboard, acknowledge
    task automatic recv1(input logic clr);
        int lat;
        logic [17:0] e;
        lat = 0;
        while (res_valid1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != 1 || alu_sel1 !== 12'h800) begin
            n_fail++;
            $display("FAIL latency1 got %0d sel=%h want 1 sel=800", lat, alu_sel1);
        end
        e = (q1.size() > 0) ? q1.pop_front() : 18'h3FFFF;
        n_tests++;
        if ({res_err1, res_cout1, res_data1} !== e) begin
            n_fail++;
            $display("FAIL result1 got err=%b cout=%b data=%h want err=%b cout=%b data=%h",
                     res_err1, res_cout1, res_data1, e[17], e[16], e[15:0]);
        end
        res_ready1 = 1'b1;
        acc_clr1 = clr;
        @(posedge clk); #1;
        res_ready1 = 1'b0;
        acc_clr1 = 1'b0;
        exp_acc1 = clr ? 16'h0 : e[15:0];
        n_tests++;
        if (acc_q1 !== exp_acc1 || res_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL acc1 got acc=%h valid=%b want acc=%h valid=0",
                     acc_q1, res_valid1, exp_acc1);
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if (alu_sel1 !== 12'h800 || cmd_ready1 !== 1'b1 || res_valid1 !== 1'b0 ||
            acc_q1 !== 16'h0 || res_data1 !== 16'h0 || alu_a1 !== 16'h0 ||
            cmd_ready3 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset got sel=%h crdy=%b rv=%b acc=%h rd=%h a=%h",
                     alu_sel1, cmd_ready1, res_valid1, acc_q1, res_data1, alu_a1);
        end
    endtask

    task automatic test_add_chain;
        send1(4'h8, 16'h00FF, 16'h0001, 1'b0);
        recv1(1'b0);
        send1(4'h9, 16'h1234, 16'h0100, 1'b1);
        recv1(1'b0);
    endtask

    task automatic test_ops;
        logic [3:0]  ops[6];
        logic [15:0] as[6];
        logic [15:0] bs[6];
        ops = '{4'h8, 4'h9, 4'hB, 4'hA, 4'h6, 4'h2};
        as  = '{16'hFFFF, 16'h0001, 16'h8001, 16'h0003, 16'hF0F0, 16'h1234};
        bs  = '{16'h0002, 16'h0002, 16'h0000, 16'h0000, 16'hFF00, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            send1(ops[i], as[i], bs[i], 1'b0);
            recv1(1'b0);
        end
    endtask

    task automatic test_illegal;
        send1(4'hF, 16'h1234, 16'h5678, 1'b0);
        recv1(1'b0);
        send1(4'h7, 16'hAAAA, 16'h5555, 1'b0);
        recv1(1'b0);
        send1(4'h1, 16'h00F0, 16'h000F, 1'b0);
        recv1(1'b0);
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [17:0] e;
        cmd_op3 = 4'h8; cmd_a3 = 16'h0001; cmd_b3 = 16'h0002; cmd_use3 = 1'b0;
        cmd_valid3 = 1'b1;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        q3.push_back(exp_f(4'h8, 16'h0001, 16'h0002));
        lat = 0;
        while (res_valid3 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL latency3 got %0d want 3", lat);
        end
        e = (q3.size() > 0) ? q3.pop_front() : 18'h3FFFF;
        cmd_op3 = 4'h3; cmd_a3 = 16'h00F0; cmd_b3 = 16'h0F0F;
        cmd_valid3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (res_valid3 !== 1'b1 || {res_err3, res_cout3, res_data3} !== e ||
                cmd_ready3 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold3[%0d] got rv=%b data=%h crdy=%b want rv=1 data=%h crdy=0",
                         i, res_valid3, res_data3, cmd_ready3, e[15:0]);
            end
            @(posedge clk); #1;
        end
        res_ready3 = 1'b1;
        @(posedge clk); #1;
        res_ready3 = 1'b0;
        exp_acc3 = e[15:0];
        n_tests++;
        if (cmd_ready3 !== 1'b1 || alu_sel3 !== 12'h800 || acc_q3 !== exp_acc3) begin
            n_fail++;
            $display("FAIL ack3 got crdy=%b sel=%h acc=%h want crdy=1 sel=800 acc=%h",
                     cmd_ready3, alu_sel3, acc_q3, exp_acc3);
        end
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        q3.push_back(exp_f(4'h3, 16'h00F0, 16'h0F0F));
        n_tests++;
        if (cmd_ready3 !== 1'b0 || alu_sel3 !== 12'h008) begin
            n_fail++;
            $display("FAIL accept3 got crdy=%b sel=%h want crdy=0 sel=008",
                     cmd_ready3, alu_sel3);
        end
        lat = 0;
        while (res_valid3 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = (q3.size() > 0) ? q3.pop_front() : 18'h3FFFF;
        n_tests++;
        if (lat != 3 || {res_err3, res_cout3, res_data3} !== e) begin
            n_fail++;
            $display("FAIL result3 got lat=%0d data=%h want lat=3 data=%h",
                     lat, res_data3, e[15:0]);
        end
        res_ready3 = 1'b1;
        @(posedge clk); #1;
        res_ready3 = 1'b0;
        exp_acc3 = e[15:0];
    endtask

    task automatic test_reset_exec;
        cmd_op3 = 4'h8; cmd_a3 = 16'hAAAA; cmd_b3 = 16'h5555; cmd_use3 = 1'b0;
        cmd_valid3 = 1'b1;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        n_tests++;
        if (cmd_ready3 !== 1'b0 || alu_sel3 !== 12'h080 || acc_q3 !== exp_acc3) begin
            n_fail++;
            $display("FAIL exec3 got crdy=%b sel=%h acc=%h want crdy=0 sel=080 acc=%h",
                     cmd_ready3, alu_sel3, acc_q3, exp_acc3);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (alu_sel3 !== 12'h800 || alu_a3 !== 16'h0 || alu_b3 !== 16'h0 ||
            cmd_ready3 !== 1'b1 || res_valid3 !== 1'b0 || acc_q3 !== 16'h0 ||
            res_data3 !== 16'h0 || acc_q1 !== 16'h0) begin
            n_fail++;
            $display("FAIL async_rst got sel=%h a=%h b=%h crdy=%b rv=%b acc=%h want reset values",
                     alu_sel3, alu_a3, alu_b3, cmd_ready3, res_valid3, acc_q3);
        end
        #1 rst_n = 1'b1;
        q3.delete();
        exp_acc1 = 16'h0;
        exp_acc3 = 16'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_clr_coincident;
        send1(4'h8, 16'h0010, 16'h0000, 1'b0);
        recv1(1'b0);
        send1(4'h8, 16'h0003, 16'h0004, 1'b1);
        recv1(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid1 = 1'b0; cmd_op1 = 4'h0; cmd_a1 = 16'h0; cmd_b1 = 16'h0;
        cmd_use1 = 1'b0; acc_clr1 = 1'b0; res_ready1 = 1'b0;
        cmd_valid3 = 1'b0; cmd_op3 = 4'h0; cmd_a3 = 16'h0; cmd_b3 = 16'h0;
        cmd_use3 = 1'b0; acc_clr3 = 1'b0; res_ready3 = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_add_chain;
        test_ops;
        test_illegal;
        test_back_to_back;
        test_reset_exec;
        test_clr_coincident;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
